sp_ram_resp: RTL and testbench

- Memory-side responder for sp_ram_intf: a single-port scratchpad buffer (param/bias/input/weight/output banks) serving two requesters, the host/DMA loader and a compute engine.
- An ownership FSM switches the one physical port between requesters.
- Implements synchronous 1-cycle read, `WRITE_ENB`/`WRITE_DIS` write encoding from conv_acc.svh, oe gating, out-of-range protection and access counters.

---
 rtl/sp_ram_resp_if.sv | 37 +++
 rtl/sp_ram_resp.sv | 138 +++++++++++++
 tb/tb_sp_ram_resp.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_resp_if.sv
// sp_ram_intf: scratchpad port bundle shared by host/DMA and compute.
// W_req encoding lives here so both ends agree on it.
`ifndef WRITE_ENB
`define WRITE_ENB 1'b1
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 1'b0
`endif

interface sp_ram_intf #(
  parameter int DATA_W = 32
);
  logic              cs;
  logic              oe;
  logic              W_req;
  logic [31:0]       addr;
  logic [DATA_W-1:0] W_data;
  logic [DATA_W-1:0] R_data;

  modport memory (
    input  cs,
    input  oe,
    input  W_req,
    input  addr,
    input  W_data,
    output R_data
  );

  modport master (
    output cs,
    output oe,
    output W_req,
    output addr,
    output W_data,
    input  R_data
  );
endinterface

// File: rtl/sp_ram_resp.sv
// sp_ram_resp: single-port scratchpad bank shared by host and compute,
// with ownership handover, oe gating, range guard and access counters.
module sp_ram_resp #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  sp_ram_intf.memory       host_intf,
  sp_ram_intf.memory       compute_intf,
  input  logic             own_req,
  output logic             compute_own,
  output logic             host_own,
  output logic             oob_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    OWN_H,
    DRN_C,
    OWN_C,
    DRN_H
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_h;
  logic [DATA_W-1:0] rd_c;

  logic              cs;
  logic              wreq;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              in_rng;
  logic              wr_go;
  logic              rd_go;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] rd_val;

  // Only the owning side reaches the port; drain states mute both.
  always_comb begin
    cs    = 1'b0;
    wreq  = `WRITE_DIS;
    addr  = '0;
    wdata = '0;
    case (state)
      OWN_H: begin
        cs    = host_intf.cs;
        wreq  = host_intf.W_req;
        addr  = host_intf.addr;
        wdata = host_intf.W_data;
      end
      OWN_C: begin
        cs    = compute_intf.cs;
        wreq  = compute_intf.W_req;
        addr  = compute_intf.addr;
        wdata = compute_intf.W_data;
      end
      default: ;
    endcase
  end

  assign in_rng = ({1'b0, addr} < 33'(DEPTH));
  assign wr_go  = cs && (wreq == `WRITE_ENB);
  assign rd_go  = cs && (wreq == `WRITE_DIS);
  assign idx    = addr[AW-1:0];
  assign rd_val = in_rng ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (wr_go && in_rng)
      mem[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= OWN_H;
      host_own    <= 1'b1;
      compute_own <= 1'b0;
      oob_err     <= 1'b0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      rd_h        <= '0;
      rd_c        <= '0;
    end else begin
      if (cs && !in_rng)
        oob_err <= 1'b1;

      if (rd_go) begin
        if (state == OWN_H)
          rd_h <= rd_val;
        else
          rd_c <= rd_val;
      end

      if (wr_go && in_rng && (wr_cnt != '1))
        wr_cnt <= wr_cnt + 1'b1;
      if (rd_go && in_rng && (rd_cnt != '1))
        rd_cnt <= rd_cnt + 1'b1;

      // Handover clears counters, overriding any same-cycle increment.
      case (state)
        OWN_H: begin
          if (own_req) begin
            state    <= DRN_C;
            host_own <= 1'b0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
          end
        end
        DRN_C: begin
          state       <= OWN_C;
          compute_own <= 1'b1;
        end
        OWN_C: begin
          if (!own_req) begin
            state       <= DRN_H;
            compute_own <= 1'b0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
          end
        end
        default: begin
          state    <= OWN_H;
          host_own <= 1'b1;
        end
      endcase
    end
  end

  assign host_intf.R_data    = host_intf.oe ? rd_h : '0;
  assign compute_intf.R_data = compute_intf.oe ? rd_c : '0;

endmodule

// File: tb/tb_sp_ram_resp.sv
// tb_sp_ram_resp: scoreboard bench for the shared scratchpad bank.
// Reads push expected data; the response cycle pops and compares.
`ifndef WRITE_ENB
`define WRITE_ENB 1'b1
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 1'b0
`endif

module tb_sp_ram_resp;

  localparam int DEPTH = 4096;
  localparam int DW    = 32;
  localparam int CW    = 32;

  logic          clk;
  logic          rst;
  logic          own_req;
  logic          compute_own;
  logic          host_own;
  logic          oob_err;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;

  sp_ram_intf #(.DATA_W(DW)) h_if ();
  sp_ram_intf #(.DATA_W(DW)) c_if ();

  sp_ram_resp #(
    .DEPTH  (DEPTH),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .host_intf    (h_if),
    .compute_intf (c_if),
    .own_req      (own_req),
    .compute_own  (compute_own),
    .host_own     (host_own),
    .oob_err      (oob_err),
    .rd_cnt       (rd_cnt),
    .wr_cnt       (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [int];
  logic [31:0] q_h [$];
  logic [31:0] q_c [$];
  bit          c_owns;
  int          e_rd;
  int          e_wr;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // side: 0 host, 1 compute; w: 1 write, 0 read
  task automatic acc(
    input bit          side,
    input bit          w,
    input logic [31:0] a,
    input logic [31:0] d
  );
    logic [31:0] v;
    bit          own;
    bit          oe;
    own = (side == c_owns);
    oe  = side ? c_if.oe : h_if.oe;
    if (side) begin
      c_if.cs     = 1'b1;
      c_if.W_req  = w ? `WRITE_ENB : `WRITE_DIS;
      c_if.addr   = a;
      c_if.W_data = d;
    end else begin
      h_if.cs     = 1'b1;
      h_if.W_req  = w ? `WRITE_ENB : `WRITE_DIS;
      h_if.addr   = a;
      h_if.W_data = d;
    end
    if (!w && own) begin
      v = 32'h0;
      if (a < DEPTH && model.exists(int'(a)))
        v = model[int'(a)];
      if (!oe)
        v = 32'h0;
      if (side)
        q_c.push_back(v);
      else
        q_h.push_back(v);
    end
    if (own && a < DEPTH) begin
      if (w) begin
        model[int'(a)] = d;
        e_wr++;
      end else begin
        e_rd++;
      end
    end
    tick();
    h_if.cs = 1'b0;
    c_if.cs = 1'b0;
    if (!w && own) begin
      if (side)
        check("c_rd", c_if.R_data, q_c.pop_front());
      else
        check("h_rd", h_if.R_data, q_h.pop_front());
    end
  endtask

  task automatic chk_cnt(input string tag);
    check({tag, "_rd"}, rd_cnt, e_rd);
    check({tag, "_wr"}, wr_cnt, e_wr);
  endtask

  initial begin
    rst         = 1'b0;
    own_req     = 1'b0;
    h_if.cs     = 1'b0;
    h_if.oe     = 1'b1;
    h_if.W_req  = `WRITE_DIS;
    h_if.addr   = '0;
    h_if.W_data = '0;
    c_if.cs     = 1'b0;
    c_if.oe     = 1'b1;
    c_if.W_req  = `WRITE_DIS;
    c_if.addr   = '0;
    c_if.W_data = '0;
    c_owns      = 1'b0;
    e_rd        = 0;
    e_wr        = 0;

    repeat (3) tick();
    check("rst_hown", host_own, 1);
    check("rst_cown", compute_own, 0);
    check("rst_oob", oob_err, 0);
    check("rst_hdat", h_if.R_data, 0);
    check("rst_cdat", c_if.R_data, 0);
    chk_cnt("rst");
    rst = 1'b1;
    tick();

    acc(0, 1, 0, 32'h11);
    acc(0, 1, 1, 32'h22);
    acc(0, 1, 2, 32'h33);
    acc(0, 0, 1, 0);
    chk_cnt("host");

    own_req = 1'b1;
    tick();
    check("drn_hown", host_own, 0);
    check("drn_cown", compute_own, 0);
    check("drn_hdat", h_if.R_data, 32'h22);
    tick();
    check("own_cown", compute_own, 1);
    check("own_hown", host_own, 0);
    c_owns = 1'b1;
    e_rd   = 0;
    e_wr   = 0;
    chk_cnt("clr");

    acc(1, 1, 5, 32'h7f);
    acc(1, 0, 5, 0);
    chk_cnt("cmp");
    acc(1, 0, 2, 0);
    acc(0, 1, 2, 32'hdead);
    acc(1, 0, 2, 0);
    chk_cnt("ign");

    acc(1, 0, DEPTH + 3, 0);
    check("oob_set", oob_err, 1);
    acc(1, 1, DEPTH, 32'h55);
    acc(1, 0, 0, 0);
    check("oob_hold", oob_err, 1);
    chk_cnt("oob");

    own_req = 1'b0;
    tick();
    tick();
    check("back_hown", host_own, 1);
    c_owns = 1'b0;
    e_rd   = 0;
    e_wr   = 0;

    h_if.oe = 1'b0;
    acc(0, 0, 1, 0);
    tick();
    h_if.oe = 1'b1;
    #1;
    check("oe_hold", h_if.R_data, 32'h22);
    chk_cnt("oe");

    own_req = 1'b1;
    tick();
    tick();
    c_owns      = 1'b1;
    c_if.cs     = 1'b1;
    c_if.W_req  = `WRITE_ENB;
    c_if.addr   = 0;
    c_if.W_data = 32'h99;
    rst         = 1'b0;
    #1;
    check("mrst_hown", host_own, 1);
    check("mrst_cown", compute_own, 0);
    tick();
    c_if.cs = 1'b0;
    check("mrst_oob", oob_err, 0);
    check("mrst_cdat", c_if.R_data, 0);
    e_rd = 0;
    e_wr = 0;
    chk_cnt("mrst");
    rst = 1'b1;
    #1;
    check("rel_hown", host_own, 1);
    tick();
    check("rel_drn", host_own | compute_own, 0);
    tick();
    check("rel_cown", compute_own, 1);
    acc(1, 0, 0, 0);
    chk_cnt("fin");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
